multi_inst_rob: RTL
===================

// Module: multi_inst_rob
// PURPOSE
//  Parametrised in-order reorder buffer; successor to the single-instruction ROB in the COM stage.
//  Accepts up to 2 dispatches/cycle (entry index = RRF tag from the rename allocator) and FIN_PORTS
//  completion reports/cycle from EX, and retires up to COM_WIDTH entries/cycle in program order.
//  Retire outputs drive ARF commit in ReNameUnit.
// PARAMETERS
//  DEPTH      64  entries; power of 2, equals RRF size
//  SEL        6   log2(DEPTH); index/pointer width
//  FIN_PORTS  4   completion ports (alu, branch, mul, ldst)
//  COM_WIDTH  2   max retires/cycle; 1 or 2
// PORTS
//  clk_i              in   1              clock
//  reset_i            in   1              reset, asynchronous, active-low
//  dp1_i              in   1              dispatch slot 1 valid
//  dp1_addr_i         in   SEL            slot 1 entry (RRF tag)
//  pc_dp1_i           in   32             slot 1 PC
//  dstvalid_dp1_i     in   1              slot 1 writes a register
//  dst_dp1_i          in   5              slot 1 arch dest
//  dp2_i/dp2_addr_i/pc_dp2_i/dstvalid_dp2_i/dst_dp2_i   in   as slot 1   dispatch slot 2
//  finish_i           in   FIN_PORTS      per-port completion strobe
//  finish_addr_i      in   FIN_PORTS*SEL  per-port entry, port k at [k*SEL +: SEL]
//  rob_allocatable_o  out  1              count <= DEPTH-2
//  count_o            out  SEL+1          occupied entries
//  overflow_o         out  1              sticky protocol-violation flag
//  commit_ptr_1_o     out  SEL            head index (tag of retire 1)
//  arfwe_1_o          out  1              retire 1 valid and writes reg
//  dst_arf_1_o        out  5              retire 1 arch dest
//  commit_ptr_2_o     out  SEL            head+1 mod DEPTH
//  arfwe_2_o          out  1              retire 2 valid and writes reg
//  dst_arf_2_o        out  5              retire 2 arch dest
//  comnum_o           out  2              retires this cycle (0..COM_WIDTH)
//  commit_pc_1_o/commit_pc_2_o  out  32   retired PCs (see CONFIGURATION)
// BEHAVIOUR
//  Clocking/reset: one clock; reset is asynchronous and active-low.
//  Reset: head=0, count=0, all valid/finished bits=0, overflow_o=0.
//   Hence comnum_o=0, arfwe_*=0, commit_ptr_1_o=0, commit_ptr_2_o=1, rob_allocatable_o=1.
//  Per-entry state: valid, finished, dstvalid, dst[4:0], (pc).
//  Dispatch (edge):
//   - dpk_i sets valid=1, finished=0 and stores fields at dpk_addr_i.
//   - dp2_i without dp1_i is legal; dp2_addr_i must equal dp1_addr_i+1 mod DEPTH when both are set.
//   - Dispatch to an already-valid entry not retiring this cycle is dropped and sets overflow_o
//     (sticky until reset).
//  Finish (edge):
//   - finish_i[k] sets finished=1 at finish_addr_i[k] only if that entry is valid; otherwise ignored.
//   - Multiple ports naming the same entry are harmless.
//   - Finish to an entry being dispatched the same cycle is ignored (dispatch wins, finished=0).
//  Retire (combinational from registered state):
//   - c1 = valid[head] & finished[head].
//   - c2 = (COM_WIDTH==2) & c1 & valid[head+1] & finished[head+1].
//   - arfwe_k = ck & dstvalid; dst_arf_k = stored dst.
//   - comnum_o = c1+c2.
//   - Edge: clear valid of retired entries; head += comnum_o (mod DEPTH, wraps DEPTH-1 -> 0).
//  Latency: finish at edge t makes the entry retirable in cycle t+1 (combinationally visible after t).
//  count_next = count + dp1_i + dp2_i - comnum_o, excluding dropped dispatches.
//   Dispatch into an entry retiring the same cycle is allowed, so full-to-full throughput is sustained.
//  Retire 2 never bypasses a stalled retire 1; entries are strictly in order.
//  Reset asserted mid-operation discards all entries immediately (async); no retire after deassert
//   until a new dispatch+finish.
// CONFIGURATION
//  ROB_PC_TRACE_EN defined:
//   - per-entry 32-bit pc storage.
//   - commit_pc_k_o = stored pc when ck, else 0.
//  ROB_PC_TRACE_EN undefined:
//   - no pc storage; pc_dp*_i unused.
//   - commit_pc_k_o tied to 0.
// TESTING
//  1 Reset, dp1 tag 0 dst x5 dstvalid, finish port0 tag 0 next cycle -> following cycle
//    comnum_o=1, arfwe_1_o=1, dst_arf_1_o=5, then commit_ptr_1_o=1, count_o=0.
//  2 Dispatch tags 0,1 together, finish tag1 then tag0 a cycle later -> nothing retires until tag0
//    finished, then comnum_o=2 in one cycle, head=2.
//  3 COM_WIDTH=1, same as 2 -> two consecutive cycles comnum_o=1; dst_arf_1_o in program order.
//  4 Fill DEPTH entries, wrap: head=62, dispatch 62,63,0,1 -> rob_allocatable_o=0 at count 63;
//    retires 63->0 cross wrap, commit_ptr_2_o=0 when head=63.
//  5 Finish to invalid tag 10, dispatch to valid unretired tag 3 -> no state change for 10,
//    overflow_o=1 and stays 1 until reset_i low.
//  6 With ROB_PC_TRACE_EN, pc_dp1_i=0x80000010 -> commit_pc_1_o=0x80000010 on retire; without
//    the macro -> 0.

Source files
------------

// File: rtl/multi_inst_rob.sv
// In-order reorder buffer: two dispatches, FIN_PORTS completions and up to COM_WIDTH retires per cycle.
// Retire outputs are combinational from registered state. Optional per-entry PC trace under ROB_PC_TRACE_EN.
module multi_inst_rob #(
   parameter int DEPTH     = 64,
   parameter int SEL       = 6,
   parameter int FIN_PORTS = 4,
   parameter int COM_WIDTH = 2
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     dp1_i,
   input  logic [SEL-1:0]           dp1_addr_i,
   input  logic [31:0]              pc_dp1_i,
   input  logic                     dstvalid_dp1_i,
   input  logic [4:0]               dst_dp1_i,
   input  logic                     dp2_i,
   input  logic [SEL-1:0]           dp2_addr_i,
   input  logic [31:0]              pc_dp2_i,
   input  logic                     dstvalid_dp2_i,
   input  logic [4:0]               dst_dp2_i,
   input  logic [FIN_PORTS-1:0]     finish_i,
   input  logic [FIN_PORTS*SEL-1:0] finish_addr_i,
   output logic                     rob_allocatable_o,
   output logic [SEL:0]             count_o,
   output logic                     overflow_o,
   output logic [SEL-1:0]           commit_ptr_1_o,
   output logic                     arfwe_1_o,
   output logic [4:0]               dst_arf_1_o,
   output logic [SEL-1:0]           commit_ptr_2_o,
   output logic                     arfwe_2_o,
   output logic [4:0]               dst_arf_2_o,
   output logic [1:0]               comnum_o,
   output logic [31:0]              commit_pc_1_o,
   output logic [31:0]              commit_pc_2_o
);
   localparam int CW = SEL + 1;

   logic [DEPTH-1:0]      valid_q, valid_d;
   logic [DEPTH-1:0]      fin_q, fin_d;
   logic [DEPTH-1:0]      dstv_q, dstv_d;
   logic [DEPTH-1:0][4:0] dst_q, dst_d;
   logic [SEL-1:0]        head_q, head_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  overflow_q, overflow_d;

   logic [SEL-1:0] head_nx;
   logic           c1, c2;
   logic           acc1, acc2;
   logic [1:0]     comnum;

   assign head_nx = head_q + SEL'(1);
   assign c1      = valid_q[head_q] & fin_q[head_q];
   assign c2      = (COM_WIDTH == 2) & c1 & valid_q[head_nx] & fin_q[head_nx];
   assign comnum  = {1'b0, c1} + {1'b0, c2};

   // A slot freed by this cycle's retire may be re-dispatched in the same cycle.
   assign acc1 = dp1_i & (~valid_q[dp1_addr_i] | (c1 & (dp1_addr_i == head_q))
                                               | (c2 & (dp1_addr_i == head_nx)));
   assign acc2 = dp2_i & (~valid_q[dp2_addr_i] | (c1 & (dp2_addr_i == head_q))
                                               | (c2 & (dp2_addr_i == head_nx)));

   always_comb begin
      valid_d = valid_q;
      fin_d   = fin_q;
      dstv_d  = dstv_q;
      dst_d   = dst_q;
      if (c1) valid_d[head_q]  = 1'b0;
      if (c2) valid_d[head_nx] = 1'b0;
      for (int k = 0; k < FIN_PORTS; k++) begin
         if (finish_i[k] && valid_q[finish_addr_i[k*SEL +: SEL]])
            fin_d[finish_addr_i[k*SEL +: SEL]] = 1'b1;
      end
      // Dispatch is applied last so it overrides a same-cycle finish to the same slot.
      if (acc1) begin
         valid_d[dp1_addr_i] = 1'b1;
         fin_d[dp1_addr_i]   = 1'b0;
         dstv_d[dp1_addr_i]  = dstvalid_dp1_i;
         dst_d[dp1_addr_i]   = dst_dp1_i;
      end
      if (acc2) begin
         valid_d[dp2_addr_i] = 1'b1;
         fin_d[dp2_addr_i]   = 1'b0;
         dstv_d[dp2_addr_i]  = dstvalid_dp2_i;
         dst_d[dp2_addr_i]   = dst_dp2_i;
      end
      overflow_d = overflow_q | (dp1_i & ~acc1) | (dp2_i & ~acc2);
      head_d     = head_q + SEL'(comnum);
      count_d    = count_q + CW'(acc1) + CW'(acc2) - CW'(comnum);
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         valid_q    <= '0;
         fin_q      <= '0;
         dstv_q     <= '0;
         dst_q      <= '0;
         head_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         fin_q      <= fin_d;
         dstv_q     <= dstv_d;
         dst_q      <= dst_d;
         head_q     <= head_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign rob_allocatable_o = (count_q <= CW'(DEPTH - 2));
   assign count_o           = count_q;
   assign overflow_o        = overflow_q;
   assign commit_ptr_1_o    = head_q;
   assign commit_ptr_2_o    = head_nx;
   assign arfwe_1_o         = c1 & dstv_q[head_q];
   assign arfwe_2_o         = c2 & dstv_q[head_nx];
   assign dst_arf_1_o       = dst_q[head_q];
   assign dst_arf_2_o       = dst_q[head_nx];
   assign comnum_o          = comnum;

`ifdef ROB_PC_TRACE_EN
   logic [DEPTH-1:0][31:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (acc1) pc_d[dp1_addr_i] = pc_dp1_i;
      if (acc2) pc_d[dp2_addr_i] = pc_dp2_i;
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) pc_q <= '0;
      else          pc_q <= pc_d;
   end

   assign commit_pc_1_o = c1 ? pc_q[head_q]  : 32'd0;
   assign commit_pc_2_o = c2 ? pc_q[head_nx] : 32'd0;
`else
   wire unused_pc = &{1'b0, pc_dp1_i, pc_dp2_i};
   assign commit_pc_1_o = 32'd0;
   assign commit_pc_2_o = 32'd0;
`endif

endmodule
